// File: rtl/nss_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Provides the FSM state enum, the slice width and a counter-width helper.
package nss_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Counter width for a given number of slice iterations; never below 1 bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nss_nibble_slice.sv
// Combinational 4-bit adder slice with carry-in, reused once per nibble.
// Ports: x, y (4-bit addends), cin -> sum (4-bit), cout, c3 (carry into
// bit 3, present only with NSS_OVF_EN for signed-overflow detection).
import nss_pkg::*;

module nss_nibble_slice (
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
`ifdef NSS_OVF_EN
    ,
    output logic                c3
`endif
);

    // Split at bit 3 so the carry into the MSB is a real internal node.
    logic [3:0] lo;
    logic [1:0] hi;

    assign lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
    assign hi = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, lo[3]};

    assign sum  = {hi[0], lo[2:0]};
    assign cout = hi[1];

`ifdef NSS_OVF_EN
    assign c3 = lo[3];
`endif

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - b_in, one nibble per clock
// through a single reused slice. Optional signed overflow via NSS_OVF_EN.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, b_in operand
// port; out_valid/out_ready + diff, b_out (and ovf) result port.
import nss_pkg::*;

module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef NSS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;

    logic [NIBBLE_W-1:0] s_sum;
    logic                s_cout;
`ifdef NSS_OVF_EN
    logic                s_c3;
`endif

    // Subtraction as a + ~b + ~b_in; b and b_in are inverted at capture.
    nss_nibble_slice u_slice (
        .x    (a_q[NIBBLE_W*cnt +: NIBBLE_W]),
        .y    (nb_q[NIBBLE_W*cnt +: NIBBLE_W]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
`ifdef NSS_OVF_EN
        ,
        .c3   (s_c3)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            b_out     <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            nb_q      <= '0;
`ifdef NSS_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        carry    <= ~b_in;
                        diff     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff[NIBBLE_W*cnt +: NIBBLE_W] <= s_sum;
                    carry <= s_cout;
                    if (cnt == LAST) begin
                        // A final carry of 1 means no borrow was needed.
                        b_out     <= ~s_cout;
`ifdef NSS_OVF_EN
                        ovf       <= s_c3 ^ s_cout;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor.
// Covers reset state, latency, borrow, overflow, backpressure and mid-run reset.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
`ifdef NSS_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
`ifdef NSS_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns cycles waited.
    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic accept(input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = va;
        b        = vb;
        b_in     = vbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] va,
                          input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb,
                          input logic eo);
        int cyc;
        accept(va, vb, vbin);
        wait_valid(tag, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd4);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_b_out"}, 32'(b_out), 32'(eb));
`ifdef NSS_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_low"}, 32'(out_valid), 32'd0);
        check({tag, "_diff_held"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
`ifdef NSS_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        run_op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("v3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("v4", 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("v5", 16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("v6", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op("v7", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Backpressure with ignored operands during RUN.
        accept(16'h4321, 16'h1111, 1'b0);
        a        = 16'hAAAA;
        b        = 16'h5555;
        b_in     = 1'b1;
        in_valid = 1'b1;
        check("bp_in_ready_run", 32'(in_ready), 32'd0);
        tick();
        check("bp_in_ready_run2", 32'(in_ready), 32'd0);
        wait_valid("bp", cyc);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_diff", 32'(diff), 32'h3210);
            check("bp_b_out", 32'(b_out), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_false_accept", 32'(in_ready), 32'd1);

        // Reset in the second RUN cycle aborts the operation.
        accept(16'h1234, 16'h0234, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_b_out", 32'(b_out), 32'd0);
        run_op("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
